// File: rtl/matrix_mult_seq_pkg.sv
// Shared definitions for the sequential matrix multiplier: FSM encoding and default sizes.
package matrix_mult_seq_pkg;

  localparam int unsigned DEF_N             = 3;
  localparam int unsigned DEF_ENTRY_SIZE    = 5;
  localparam int unsigned DEF_RESENTRY_SIZE = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Accumulator width that holds a full N-term dot product of ew-bit entries.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned ew);
    return 2 * ew + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Operand/result handshake bundle for matrix_mult_seq.
interface matrix_mult_seq_if
  import matrix_mult_seq_pkg::*;
#(
  parameter int unsigned N             = DEF_N,
  parameter int unsigned ENTRY_SIZE    = DEF_ENTRY_SIZE,
  parameter int unsigned RESENTRY_SIZE = DEF_RESENTRY_SIZE
);

  logic                          in_valid;
  logic                          in_ready;
  logic [N*N*ENTRY_SIZE-1:0]     matrixA;
  logic [N*N*ENTRY_SIZE-1:0]     matrixB;
  logic                          out_valid;
  logic                          out_ready;
  logic [N*N*RESENTRY_SIZE-1:0]  matrixC;
  logic                          overflow;

  modport master (
    output in_valid, matrixA, matrixB, out_ready,
    input  in_ready, out_valid, matrixC, overflow
  );

  modport slave (
    input  in_valid, matrixA, matrixB, out_ready,
    output in_ready, out_valid, matrixC, overflow
  );

endinterface

// File: rtl/matrix_mult_seq_mac_unit.sv
// Multiply-accumulate datapath: registered accumulator plus combinational running sum.
module mac_unit #(
  parameter int unsigned ENTRY_SIZE = 5,
  parameter int unsigned ACC_SIZE   = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ENTRY_SIZE-1:0] i_a,
  input  logic [ENTRY_SIZE-1:0] i_b,
  input  logic                  i_clr,
  input  logic                  i_en,
  output logic [ACC_SIZE-1:0]   o_acc,
  output logic [ACC_SIZE-1:0]   o_sum_c
);

  logic [ACC_SIZE-1:0] r_acc;

  // Current accumulator plus this cycle's product; the caller may consume it on the last term.
  assign o_sum_c = r_acc + ACC_SIZE'(i_a) * ACC_SIZE'(i_b);
  assign o_acc   = r_acc;

  // Clear has priority so the last term of a dot product leaves the accumulator ready for the next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum_c;
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential N x N matrix multiplier: one multiply-accumulate per clock, row-major result order.
module matrix_mult_seq
  import matrix_mult_seq_pkg::*;
#(
  parameter int unsigned N             = DEF_N,
  parameter int unsigned ENTRY_SIZE    = DEF_ENTRY_SIZE,
  parameter int unsigned RESENTRY_SIZE = DEF_RESENTRY_SIZE
) (
  input  logic              clk,
  input  logic              reset_n,
  matrix_mult_seq_if.slave  bus
);

  localparam int unsigned ACC_SIZE = acc_width(N, ENTRY_SIZE);
  localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST   = CW'(N - 1);

  state_t                   r_state;
  logic [CW-1:0]            r_row;
  logic [CW-1:0]            r_col;
  logic [CW-1:0]            r_k;
  logic [ENTRY_SIZE-1:0]    r_a [N][N];
  logic [ENTRY_SIZE-1:0]    r_b [N][N];
  logic [RESENTRY_SIZE-1:0] r_c [N][N];
  logic                     r_ovf;
  logic                     r_in_ready;
  logic                     r_out_valid;

  logic                     w_accept;
  logic                     w_compute;
  logic                     w_last_k;
  logic                     w_mac_clr;
  logic                     w_trunc;
  logic [ENTRY_SIZE-1:0]    w_a_op;
  logic [ENTRY_SIZE-1:0]    w_b_op;
  logic [ACC_SIZE-1:0]      w_acc;
  logic [ACC_SIZE-1:0]      w_sum;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_compute = (r_state == COMPUTE);
  assign w_last_k  = (r_k == LAST);
  assign w_mac_clr = w_accept || (w_compute && w_last_k);
  assign w_a_op    = r_a[r_row][r_k];
  assign w_b_op    = r_b[r_k][r_col];

  mac_unit #(
    .ENTRY_SIZE (ENTRY_SIZE),
    .ACC_SIZE   (ACC_SIZE)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .i_a     (w_a_op),
    .i_b     (w_b_op),
    .i_clr   (w_mac_clr),
    .i_en    (w_compute),
    .o_acc   (w_acc),
    .o_sum_c (w_sum)
  );

  // Any nonzero bit above the kept result width marks a truncated entry.
  generate
    if (ACC_SIZE > RESENTRY_SIZE) begin : g_trunc
      assign w_trunc = |w_sum[ACC_SIZE-1:RESENTRY_SIZE];
    end else begin : g_no_trunc
      assign w_trunc = 1'b0;
    end
  endgenerate

  // Flatten the result registers, entry (0,0) in the MSBs.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign bus.matrixC[(N*N-1-(gi*N+gj))*RESENTRY_SIZE +: RESENTRY_SIZE] = r_c[gi][gj];
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.overflow  = r_ovf;

  // Control FSM with counters, operand capture and result write-back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
          r_c[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                r_a[i][j] <= bus.matrixA[(N*N-1-(i*N+j))*ENTRY_SIZE +: ENTRY_SIZE];
                r_b[i][j] <= bus.matrixB[(N*N-1-(i*N+j))*ENTRY_SIZE +: ENTRY_SIZE];
              end
            end
            r_row      <= '0;
            r_col      <= '0;
            r_k        <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (w_last_k) begin
            r_c[r_row][r_col] <= RESENTRY_SIZE'(w_sum);
            if (w_trunc) begin
              r_ovf <= 1'b1;
            end
            r_k <= '0;
            if (r_col == LAST) begin
              r_col <= '0;
              if (r_row == LAST) begin
                r_row       <= '0;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboard bench for matrix_mult_seq at N=3, 5-bit entries, 9-bit results.
module tb_matrix_mult_seq;

  localparam int unsigned N   = 3;
  localparam int unsigned EW  = 5;
  localparam int unsigned RW  = 9;
  localparam int unsigned NN  = N * N;
  localparam int          LAT = 27;
  localparam int          TMO = 200;

  typedef struct {
    logic [NN*RW-1:0] c;
    logic             ovf;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   acc_cyc = 0;
  int   hs_cyc  = 0;
  int   ma [N][N];
  int   mb [N][N];
  exp_t sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  matrix_mult_seq_if #(.N(N), .ENTRY_SIZE(EW), .RESENTRY_SIZE(RW)) bus ();

  matrix_mult_seq #(.N(N), .ENTRY_SIZE(EW), .RESENTRY_SIZE(RW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NN*EW-1:0] pack_in(input int m [N][N]);
    logic [NN*EW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[(NN-1-(i*N+j))*EW +: EW] = EW'(m[i][j]);
    return v;
  endfunction

  // Reference product: full-precision dot products, kept modulo 2^RW.
  function automatic exp_t model();
    exp_t e;
    int   s;
    e.c   = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        e.c[(NN-1-(i*N+j))*RW +: RW] = RW'(s % (1 << RW));
        if (s >= (1 << RW)) e.ovf = 1'b1;
      end
    return e;
  endfunction

  task automatic set_fill(input int va, input int vb);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = va;
        mb[i][j] = vb;
      end
  endtask

  task automatic set_identity();
    int rows [N][N];
    rows = '{'{1, 2, 3}, '{2, 3, 5}, '{3, 1, 2}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = rows[i][j];
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = int'($urandom_range(0, 31));
        mb[i][j] = int'($urandom_range(0, 31));
      end
  endtask

  task automatic issue();
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < TMO) begin
      step();
      w++;
    end
    if (w >= TMO) chk("in_ready_timeout", 128'(0), 128'(1));
    bus.matrixA  = pack_in(ma);
    bus.matrixB  = pack_in(mb);
    bus.in_valid = 1'b1;
    sb.push_back(model());
    step();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    chk("busy_in_ready", 128'(bus.in_ready), 128'(0));
  endtask

  task automatic collect(input int hold);
    int   w;
    exp_t e;
    w     = 0;
    e.c   = '0;
    e.ovf = 1'b0;
    while (bus.out_valid !== 1'b1 && w < TMO) begin
      step();
      w++;
    end
    if (w >= TMO) begin
      chk("out_valid_timeout", 128'(0), 128'(1));
      return;
    end
    chk("latency", 128'(cyc - acc_cyc), 128'(LAT));
    if (sb.size() == 0) chk("sb_empty", 128'(1), 128'(0));
    else e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      bus.matrixA  = (NN*EW)'({$urandom, $urandom});
      bus.matrixB  = (NN*EW)'({$urandom, $urandom});
      bus.in_valid = (h % 2 == 0);
      step();
      chk("hold_C", 128'(bus.matrixC), 128'(e.c));
      chk("hold_ovf", 128'(bus.overflow), 128'(e.ovf));
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
      chk("hold_out_valid", 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid = 1'b0;
    chk("C", 128'(bus.matrixC), 128'(e.c));
    chk("ovf", 128'(bus.overflow), 128'(e.ovf));
    bus.out_ready = 1'b1;
    step();
    hs_cyc        = cyc;
    bus.out_ready = 1'b0;
    chk("post_hs_out_valid", 128'(bus.out_valid), 128'(0));
    chk("post_hs_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.matrixA   = '0;
    bus.matrixB   = '0;
    reset_n       = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_C", 128'(bus.matrixC), 128'(0));
    chk("rst_ovf", 128'(bus.overflow), 128'(0));
    reset_n = 1'b1;

    // Zero A against nonzero B, issued on the first edge after reset release.
    set_fill(0, 7);
    mb[1][2] = 31;
    issue();
    collect(0);

    // Identity A reproduces B.
    set_identity();
    issue();
    collect(0);

    // All-31 operands overflow every entry: 2883 mod 512 = 323.
    set_fill(31, 31);
    issue();
    collect(0);

    // Backpressure with operand churn and ignored in_valid pulses.
    set_random();
    issue();
    collect(10);
    repeat (3) step();
    chk("bp_idle_out_valid", 128'(bus.out_valid), 128'(0));
    chk("bp_idle_in_ready", 128'(bus.in_ready), 128'(1));
    chk("bp_sb_drained", 128'(sb.size()), 128'(0));

    // Abort an overflowing operation after it has written some entries.
    set_fill(31, 31);
    issue();
    repeat (9) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    void'(sb.pop_back());
    chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_C", 128'(bus.matrixC), 128'(0));
    chk("abort_ovf", 128'(bus.overflow), 128'(0));
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
    set_identity();
    issue();
    collect(0);

    // Back-to-back at the earliest legal cycles.
    set_random();
    issue();
    collect(0);
    set_random();
    issue();
    chk("b2b_gap", 128'(acc_cyc - hs_cyc), 128'(1));
    collect(0);

    chk("sb_final", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_mult_seq.md
MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N, 3, matrix dimension (N x N); legal range 2..8.
- ENTRY_SIZE, 5, unsigned input entry width.
- RESENTRY_SIZE, 9, unsigned result entry width.

REQ-002 The block SHALL use one clock; reset is synchronous and active-low.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands A and B presented.
- in_ready, output, 1, block can accept operands.
- matrixA, input, N*N*ENTRY_SIZE, matrix A, row-major, entry (0,0) in MSBs.
- matrixB, input, N*N*ENTRY_SIZE, matrix B, same packing as matrixA.
- out_valid, output, 1, matrixC holds a completed product.
- out_ready, input, 1, consumer accepts matrixC.
- matrixC, output, N*N*RESENTRY_SIZE, C = A x B, same packing as matrixA.
- overflow, output, 1, at least one C entry was truncated.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, COMPUTE, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-006 In IDLE, the edge with in_valid=1 SHALL register matrixA and matrixB into internal operand registers, clear the row/col/k counters, the accumulator and overflow, and enter COMPUTE.
REQ-007 Operands SHALL be taken only from the internal registers after capture, so changes on matrixA/matrixB during COMPUTE or DONE have no effect.
REQ-008 In COMPUTE, each edge SHALL perform one multiply-accumulate: acc += A[row][k] * B[k][col].
- The accumulator SHALL be 2*ENTRY_SIZE + clog2(N) bits wide, so no intermediate overflow occurs.
REQ-009 When k=N-1, that edge SHALL write the final sum into C[row][col], keeping its low RESENTRY_SIZE bits (modulo 2^RESENTRY_SIZE).
- On the same edge it SHALL set overflow (sticky) if any truncated bit is nonzero, clear acc, and advance col, then row, in row-major order.
REQ-010 The edge that writes C[N-1][N-1] SHALL enter DONE.
- Latency SHALL be exactly N^3 edges from the accepting edge to the first cycle with out_valid=1 (27 for N=3).
REQ-011 In DONE, matrixC and overflow SHALL hold stable until out_ready=1, and that edge SHALL return the FSM to IDLE.
REQ-012 in_valid=1 during COMPUTE or DONE SHALL be ignored; in_valid is not queued.
REQ-013 A handshake completing in DONE and a new in_valid SHALL NOT be combined in the same cycle; the new operand is accepted no earlier than the next edge (IDLE).
REQ-014 Any edge where all result bits are unused (RESENTRY_SIZE >= 2*ENTRY_SIZE+clog2(N)) SHALL leave overflow at 0.
REQ-015 matrixC SHALL retain its last completed value in IDLE and COMPUTE.
- It SHALL be updated entry by entry during COMPUTE.
- Only its value while out_valid=1 is guaranteed.

Reset
REQ-016 While reset_n=0 at an edge, the block SHALL set:
- FSM to IDLE, all counters and acc to 0.
- matrixC to 0, overflow to 0, out_valid to 0, in_ready to 1 (from the next cycle).
REQ-017 Reset asserted mid-COMPUTE or in DONE SHALL abort the operation with no output handshake.
REQ-018 A handshake on the edge after reset release SHALL be accepted normally.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (IDLE/COMPUTE/DONE) and the default parameter constants (N=3, ENTRY_SIZE=5, RESENTRY_SIZE=9).
REQ-020 The multiply-accumulate datapath SHALL be one sub-module, mac_unit (operands, clear, enable, accumulator output).
- Counters, FSM and operand/result registers SHALL live in matrix_mult_seq.

Verification (N=3, ENTRY_SIZE=5, RESENTRY_SIZE=9)
REQ-021 The bench SHALL cover, as directed scenarios:
- Zero test: A=0, B has nonzero entries -> C=0, overflow=0, out_valid exactly 27 edges after acceptance.
- Identity test: A=I, B rows {1,2,3},{2,3,5},{3,1,2} -> C equals B, overflow=0.
- Overflow test: all entries 31 -> every C entry = 2883 mod 512 = 323, overflow=1.
- Backpressure test: out_ready held 0 for 10 cycles after out_valid; A/B inputs changed and in_valid pulsed meanwhile -> matrixC stable, in_ready=0, no new operation; first out_ready=1 edge returns to IDLE.
- Reset abort test: reset_n=0 for one edge at cycle 10 of COMPUTE -> out_valid=0, matrixC=0, overflow=0; next operation (A=I, B as above) completes correctly in 27 edges.
- Back-to-back test: two operations issued at the earliest legal cycles -> both results correct, in order, with exactly one IDLE cycle between DONE and the next COMPUTE.
